ps2_scancode_decoder: RTL and testbench

Consumes the byte stream produced by the PS/2 byte receiver (`byte_data`, `full_byte_received`) and turns scan-code-set-2 sequences into key events. It decodes the `E0` (extended), `F0` (break) and `E1` (pause) prefixes and tracks Shift and Caps Lock. Each key event carries the raw code, a make/break flag, an extended flag and an ASCII translation. Events are queued in a small FIFO behind a valid/ready port for the CPU-side I/O register block. The decoder also drives the receiver's `wait_for_data` enable.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_set2_to_ascii.sv | 79 +++++++
 rtl/ps2_scancode_decoder.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE = 8'hE1;

    localparam logic [7:0] CTRL_ERR0  = 8'h00;
    localparam logic [7:0] CTRL_BAT   = 8'hAA;
    localparam logic [7:0] CTRL_ECHO  = 8'hEE;
    localparam logic [7:0] CTRL_ACK   = 8'hFA;
    localparam logic [7:0] CTRL_RSND  = 8'hFE;
    localparam logic [7:0] CTRL_ERR1  = 8'hFF;

    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
        logic [7:0] ascii;
    } key_event_t;

    // Keyboard status/acknowledge bytes carry no key information.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == CTRL_ERR0) || (b == CTRL_BAT) || (b == CTRL_ECHO) ||
               (b == CTRL_ACK)  || (b == CTRL_RSND) || (b == CTRL_ERR1);
    endfunction

endpackage

// File: rtl/ps2_set2_to_ascii.sv
// Combinational scan-code-set-2 to ASCII translation for US layout.
module ps2_set2_to_ascii (
    input  logic [7:0] code,
    input  logic       extended,
    input  logic       key_rel,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] plain;
    logic [7:0] shifted;

    always_comb begin
        letter  = '0;
        plain   = '0;
        shifted = '0;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;  8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;  8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;  8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;  8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h45: begin plain = 8'h30; shifted = 8'h29; end
            8'h16: begin plain = 8'h31; shifted = 8'h21; end
            8'h1E: begin plain = 8'h32; shifted = 8'h40; end
            8'h26: begin plain = 8'h33; shifted = 8'h23; end
            8'h25: begin plain = 8'h34; shifted = 8'h24; end
            8'h2E: begin plain = 8'h35; shifted = 8'h25; end
            8'h36: begin plain = 8'h36; shifted = 8'h5E; end
            8'h3D: begin plain = 8'h37; shifted = 8'h26; end
            8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
            8'h46: begin plain = 8'h39; shifted = 8'h28; end
            8'h0E: begin plain = 8'h60; shifted = 8'h7E; end
            8'h4E: begin plain = 8'h2D; shifted = 8'h5F; end
            8'h55: begin plain = 8'h3D; shifted = 8'h2B; end
            8'h54: begin plain = 8'h5B; shifted = 8'h7B; end
            8'h5B: begin plain = 8'h5D; shifted = 8'h7D; end
            8'h5D: begin plain = 8'h5C; shifted = 8'h7C; end
            8'h4C: begin plain = 8'h3B; shifted = 8'h3A; end
            8'h52: begin plain = 8'h27; shifted = 8'h22; end
            8'h41: begin plain = 8'h2C; shifted = 8'h3C; end
            8'h49: begin plain = 8'h2E; shifted = 8'h3E; end
            8'h4A: begin plain = 8'h2F; shifted = 8'h3F; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            default: ;
        endcase
    end

    always_comb begin
        ascii = '0;
        if (!key_rel) begin
            if (extended) begin
                if (code == 8'h5A)
                    ascii = 8'h0D;
                else if (code == 8'h4A)
                    ascii = 8'h2F;
            end else if (letter != 8'h00) begin
                ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
            end else begin
                ascii = shift ? shifted : plain;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Prefix-decoding FSM, modifier tracking and key-event FIFO for PS/2 set 2.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       full_byte_received,
    output logic       wait_for_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_release,
    output logic       key_extended,
    output logic [7:0] key_ascii,
    output logic       shift_held,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t      state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic        lshift_q, lshift_d;
    logic        rshift_q, rshift_d;
    logic        caps_q, caps_d;
    logic        overflow_q, overflow_d;
    logic        wait_q, wait_d;
    key_event_t  mem_q [DEPTH];
    key_event_t  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic        emit, ev_rel, ev_ext;
    logic [7:0]  ev_ascii;
    logic        full, pop, push_ok;

    ps2_set2_to_ascii u_ascii (
        .code     (byte_data),
        .extended (ev_ext),
        .key_rel  (ev_rel),
        .shift    (lshift_q | rshift_q),
        .caps     (caps_q),
        .ascii    (ev_ascii)
    );

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        ev_rel  = 1'b0;
        ev_ext  = 1'b0;
        if (full_byte_received) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_data == BYTE_EXT) begin
                        state_d = EXT;
                    end else if (byte_data == BYTE_BRK) begin
                        state_d = BRK;
                    end else if (byte_data == BYTE_PAUSE) begin
                        state_d = SKIP;
                        skip_d  = PAUSE_TAIL;
                    end else if (!is_ctrl_byte(byte_data)) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (byte_data == BYTE_BRK) begin
                        state_d = EXT_BRK;
                    end else if (byte_data != BYTE_EXT) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    if (byte_data == BYTE_EXT) begin
                        state_d = EXT;
                    end else if (byte_data != BYTE_BRK) begin
                        emit    = 1'b1;
                        ev_rel  = 1'b1;
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (byte_data != BYTE_EXT && byte_data != BYTE_BRK) begin
                        emit    = 1'b1;
                        ev_rel  = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Modifiers track every emitted event, even ones the FIFO drops.
    always_comb begin
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        if (emit && !ev_ext) begin
            if (byte_data == SC_LSHIFT)
                lshift_d = !ev_rel;
            if (byte_data == SC_RSHIFT)
                rshift_d = !ev_rel;
            if (byte_data == SC_CAPS && !ev_rel)
                caps_d = !caps_q;
        end
    end

    assign full    = (cnt_q == FULL_CNT);
    assign pop     = key_valid && key_ready;
    assign push_ok = emit && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (emit && full && !pop);
        wait_d     = !full;
        if (push_ok) begin
            mem_d[wr_q] = '{code: byte_data, rel: ev_rel, ext: ev_ext, ascii: ev_ascii};
            wr_d        = wr_q + AW'(1);
        end
        if (pop)
            rd_d = rd_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            caps_q     <= 1'b0;
            overflow_q <= 1'b0;
            wait_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            caps_q     <= caps_d;
            overflow_q <= overflow_d;
            wait_q     <= wait_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign wait_for_data = wait_q;
    assign key_valid     = (cnt_q != '0);
    assign key_code      = mem_q[rd_q].code;
    assign key_release   = mem_q[rd_q].rel;
    assign key_extended  = mem_q[rd_q].ext;
    assign key_ascii     = mem_q[rd_q].ascii;
    assign shift_held    = lshift_q | rshift_q;
    assign caps_lock     = caps_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: vector table plus multi-cycle sequences.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_data = '0;
    logic       full_byte_received = 1'b0;
    logic       key_ready = 1'b0;
    logic       wait_for_data, key_valid, key_release, key_extended;
    logic       shift_held, caps_lock, overflow;
    logic [7:0] key_code, key_ascii;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.DEPTH(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .byte_data          (byte_data),
        .full_byte_received (full_byte_received),
        .wait_for_data      (wait_for_data),
        .key_valid          (key_valid),
        .key_ready          (key_ready),
        .key_code           (key_code),
        .key_release        (key_release),
        .key_extended       (key_extended),
        .key_ascii          (key_ascii),
        .shift_held         (shift_held),
        .caps_lock          (caps_lock),
        .overflow           (overflow)
    );

    typedef struct {
        logic [31:0] bytes;
        int unsigned n;
        logic        ev;
        logic [7:0]  code;
        logic        rel;
        logic        ext;
        logic [7:0]  asc;
        logic        sh;
        logic        cp;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] bytes, input int unsigned n, input logic ev,
                                input logic [7:0] code, input logic rel, input logic ext,
                                input logic [7:0] asc, input logic sh, input logic cp);
        vec_t v;
        v.bytes = bytes; v.n = n; v.ev = ev; v.code = code; v.rel = rel;
        v.ext = ext; v.asc = asc; v.sh = sh; v.cp = cp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_data = b;
        full_byte_received = 1'b1;
        @(negedge clk);
        full_byte_received = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [7:0] code, input logic rel,
                              input logic ext, input logic [7:0] asc);
        check({tag, ".valid"}, 32'(key_valid), 32'd1);
        check({tag, ".code"},  32'(key_code), 32'(code));
        check({tag, ".rel"},   32'(key_release), 32'(rel));
        check({tag, ".ext"},   32'(key_extended), 32'(ext));
        check({tag, ".ascii"}, 32'(key_ascii), 32'(asc));
    endtask

    vec_t vecs[27];

    initial begin
        vecs[0]  = mk(32'h1C000000, 1, 1, 8'h1C, 0, 0, 8'h61, 0, 0);
        vecs[1]  = mk(32'h12000000, 1, 1, 8'h12, 0, 0, 8'h00, 1, 0);
        vecs[2]  = mk(32'h1C000000, 1, 1, 8'h1C, 0, 0, 8'h41, 1, 0);
        vecs[3]  = mk(32'hF01C0000, 2, 1, 8'h1C, 1, 0, 8'h00, 1, 0);
        vecs[4]  = mk(32'hF0120000, 2, 1, 8'h12, 1, 0, 8'h00, 0, 0);
        vecs[5]  = mk(32'h58000000, 1, 1, 8'h58, 0, 0, 8'h00, 0, 1);
        vecs[6]  = mk(32'hF0580000, 2, 1, 8'h58, 1, 0, 8'h00, 0, 1);
        vecs[7]  = mk(32'h1C000000, 1, 1, 8'h1C, 0, 0, 8'h41, 0, 1);
        vecs[8]  = mk(32'h12000000, 1, 1, 8'h12, 0, 0, 8'h00, 1, 1);
        vecs[9]  = mk(32'h1C000000, 1, 1, 8'h1C, 0, 0, 8'h61, 1, 1);
        vecs[10] = mk(32'hF0120000, 2, 1, 8'h12, 1, 0, 8'h00, 0, 1);
        vecs[11] = mk(32'hE0750000, 2, 1, 8'h75, 0, 1, 8'h00, 0, 1);
        vecs[12] = mk(32'hE0F07500, 3, 1, 8'h75, 1, 1, 8'h00, 0, 1);
        vecs[13] = mk(32'hE05A0000, 2, 1, 8'h5A, 0, 1, 8'h0D, 0, 1);
        vecs[14] = mk(32'h16000000, 1, 1, 8'h16, 0, 0, 8'h31, 0, 1);
        vecs[15] = mk(32'hE0120000, 2, 1, 8'h12, 0, 1, 8'h00, 0, 1);
        vecs[16] = mk(32'h58000000, 1, 1, 8'h58, 0, 0, 8'h00, 0, 0);
        vecs[17] = mk(32'h29000000, 1, 1, 8'h29, 0, 0, 8'h20, 0, 0);
        vecs[18] = mk(32'hE04A0000, 2, 1, 8'h4A, 0, 1, 8'h2F, 0, 0);
        vecs[19] = mk(32'h4A000000, 1, 1, 8'h4A, 0, 0, 8'h2F, 0, 0);
        vecs[20] = mk(32'hAA000000, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[21] = mk(32'hF0E0F070, 4, 1, 8'h70, 1, 1, 8'h00, 0, 0);
        vecs[22] = mk(32'hE0E06B00, 3, 1, 8'h6B, 0, 1, 8'h00, 0, 0);
        vecs[23] = mk(32'h59000000, 1, 1, 8'h59, 0, 0, 8'h00, 1, 0);
        vecs[24] = mk(32'h4E000000, 1, 1, 8'h4E, 0, 0, 8'h5F, 1, 0);
        vecs[25] = mk(32'hE0F01200, 3, 1, 8'h12, 1, 1, 8'h00, 1, 0);
        vecs[26] = mk(32'hF0590000, 2, 1, 8'h59, 1, 0, 8'h00, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.wait", 32'(wait_for_data), 32'd0);
        check("rst.valid", 32'(key_valid), 32'd0);
        check("rst.code", 32'(key_code), 32'd0);
        check("rst.ascii", 32'(key_ascii), 32'd0);
        check("rst.flags", {29'd0, key_release, key_extended, overflow}, 32'd0);
        check("rst.mods", {30'd0, shift_held, caps_lock}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst.wait_rise", 32'(wait_for_data), 32'd1);

        // Single-cycle latency: nothing visible in the pulse cycle, head visible the next
        @(negedge clk);
        byte_data = 8'h1C;
        full_byte_received = 1'b1;
        check("lat.before", 32'(key_valid), 32'd0);
        @(negedge clk);
        full_byte_received = 1'b0;
        check_head("lat", 8'h1C, 1'b0, 1'b0, 8'h61);
        pop_one();
        check("lat.popped", 32'(key_valid), 32'd0);

        for (int i = 0; i < 27; i++) begin
            for (int k = 0; k < int'(vecs[i].n); k++)
                send_byte(vecs[i].bytes[31 - 8 * k -: 8]);
            if (vecs[i].ev) begin
                check_head($sformatf("vec%0d", i), vecs[i].code, vecs[i].rel, vecs[i].ext, vecs[i].asc);
            end else begin
                check($sformatf("vec%0d.valid", i), 32'(key_valid), 32'd0);
            end
            check($sformatf("vec%0d.shift", i), 32'(shift_held), 32'(vecs[i].sh));
            check($sformatf("vec%0d.caps", i), 32'(caps_lock), 32'(vecs[i].cp));
            if (key_valid)
                pop_one();
            check($sformatf("vec%0d.empty", i), 32'(key_valid), 32'd0);
        end

        // Pause sequence and control bytes are swallowed; decoding resumes in IDLE
        foreach (vecs[0].bytes[j]) begin end
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'hAA); send_byte(8'hFA);
        check("pause.valid", 32'(key_valid), 32'd0);
        send_byte(8'h1C);
        check_head("pause.after", 8'h1C, 1'b0, 1'b0, 8'h61);
        pop_one();

        // Overflow: 5 makes into a 4-deep FIFO with no consumer
        check("ovf.wait_pre", 32'(wait_for_data), 32'd1);
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        send_byte(8'h2C);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.wait", 32'(wait_for_data), 32'd0);
        check_head("ovf.head", 8'h15, 1'b0, 1'b0, 8'h71);

        // Simultaneous push and pop while full
        @(negedge clk);
        byte_data = 8'h35;
        full_byte_received = 1'b1;
        key_ready = 1'b1;
        @(negedge clk);
        full_byte_received = 1'b0;
        key_ready = 1'b0;
        check_head("pp.head", 8'h1D, 1'b0, 1'b0, 8'h77);
        check("pp.wait", 32'(wait_for_data), 32'd0);

        pop_one(); check_head("drain1", 8'h24, 1'b0, 1'b0, 8'h65);
        pop_one(); check_head("drain2", 8'h2D, 1'b0, 1'b0, 8'h72);
        pop_one(); check_head("drain3", 8'h35, 1'b0, 1'b0, 8'h79);
        pop_one();
        check("drain.empty", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("drain.wait", 32'(wait_for_data), 32'd1);
        check("drain.ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-sequence clears FSM, modifiers and overflow
        send_byte(8'h12);
        pop_one();
        check("mid.shift", 32'(shift_held), 32'd1);
        send_byte(8'hE0);
        do_reset();
        check("mid.ovf", 32'(overflow), 32'd0);
        check("mid.shift_clr", 32'(shift_held), 32'd0);
        check("mid.valid", 32'(key_valid), 32'd0);
        send_byte(8'h1C);
        check_head("mid.after", 8'h1C, 1'b0, 1'b0, 8'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
